// File: rtl/alu_sequencer.sv
// alu_sequencer: issues requests to an external multi-cycle ALU and returns a held response.
// Build option: define ALU_SEQ_MUL_EN to add shift-and-add multiply on op 1000.
module alu_sequencer #(
  parameter int n      = 64,
  parameter int SETTLE = 2
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [n-1:0] req_a,
  input  logic [n-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [3:0]   ALUCtrl,
  output logic [n-1:0] BusA,
  output logic [n-1:0] BusB,
  input  logic [n-1:0] BusW,
  input  logic         Zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'b1000;
`endif
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RESP
`ifdef ALU_SEQ_MUL_EN
    ,
    MUL_EVAL,
    MUL_WAIT
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [n-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         err_q, err_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic [n-1:0] bus_a_q, bus_a_d;
  logic [n-1:0] bus_b_q, bus_b_d;
  logic         settle_done;
`ifdef ALU_SEQ_MUL_EN
  logic [n-1:0] acc_q, acc_d;
  logic [n-1:0] mcand_q, mcand_d;
  logic [n-1:0] mplier_q, mplier_d;
`endif

  function automatic logic is_basic(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_PASSB);
  endfunction

  assign settle_done = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      ctrl_q   <= OP_PASSB;
      bus_a_q  <= '0;
      bus_b_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      ctrl_q   <= ctrl_d;
      bus_a_q  <= bus_a_d;
      bus_b_q  <= bus_b_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_basic(req_op)) state_d = ISSUE;
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == OP_MUL) state_d = MUL_EVAL;
`endif
          else state_d = RESP;
        end
      end
      ISSUE: if (settle_done) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
`ifdef ALU_SEQ_MUL_EN
      MUL_EVAL: begin
        if (mplier_q == '0) state_d = RESP;
        else if (mplier_q[0]) state_d = MUL_WAIT;
      end
      MUL_WAIT: if (settle_done) state_d = MUL_EVAL;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath: ALU drive only changes on issue; responses latch once and hold through RESP.
  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    ctrl_d   = ctrl_q;
    bus_a_d  = bus_a_q;
    bus_b_d  = bus_b_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (is_basic(req_op)) begin
            ctrl_d  = req_op;
            bus_a_d = req_a;
            bus_b_d = req_b;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == OP_MUL) begin
            mcand_d  = req_a;
            mplier_d = req_b;
            acc_d    = '0;
          end
`endif
          else begin
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 4'd1;
        if (settle_done) begin
          cnt_d    = '0;
          result_d = BusW;
          zero_d   = Zero;
          err_d    = 1'b0;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL_EVAL: begin
        if (mplier_q == '0) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          err_d    = 1'b0;
        end else if (mplier_q[0]) begin
          ctrl_d  = OP_ADD;
          bus_a_d = acc_q;
          bus_b_d = mcand_q;
          cnt_d   = '0;
        end else begin
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (settle_done) begin
          cnt_d    = '0;
          acc_d    = BusW;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign ALUCtrl    = ctrl_q;
  assign BusA       = bus_a_q;
  assign BusB       = bus_b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random requests against a behavioural model.
module tb_alu_sequencer;
  localparam int N  = 64;
  localparam int ST = 2;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_PASSB = 4'b0111, OP_MUL = 4'b1000;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         Reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err, Zero;
  logic [3:0]   req_op, ALUCtrl;
  logic [N-1:0] req_a, req_b, rsp_result, BusA, BusB, BusW;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Last values the sequencer should have driven onto the ALU.
  logic [3:0]   m_ctrl;
  logic [N-1:0] m_a, m_b;

  always #10 CLK = ~CLK;

  alu_sequencer #(.n(N), .SETTLE(ST)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB), .BusW(BusW), .Zero(Zero)
  );

  function automatic logic [N-1:0] alu_f(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    case (c)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_PASSB: return b;
      default:  return '0;
    endcase
  endfunction

  // Behavioural ALU with slow result and flag.
  assign #20 BusW = alu_f(ALUCtrl, BusA, BusB);
  assign #1 Zero = (BusW == '0);

  function automatic bit tb_basic(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB};
  endfunction

  function automatic int msb_of(input logic [N-1:0] v);
    int m = -1;
    for (int i = 0; i < N; i++) if (v[i]) m = i;
    return m;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected response and latency (edges after the accept edge); also updates the expected ALU drive.
  task automatic model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] r, output logic z, output logic e, output int lat);
    int m;
    if (tb_basic(op)) begin
      r = alu_f(op, a, b); z = (r == '0); e = 1'b0; lat = ST;
      m_ctrl = op; m_a = a; m_b = b;
    end else if (op == OP_MUL && MUL_ON) begin
      r = a * b; z = (r == '0); e = 1'b0;
      if (b == '0) lat = 1;
      else begin
        m = msb_of(b);
        lat = m + 2 + $countones(b) * ST;
        m_ctrl = OP_ADD;
        m_b = a << m;
        m_a = a * (b & ~(N'(1) << m));
      end
    end else begin
      r = '0; z = 1'b1; e = 1'b1; lat = 0;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int w = 0;
    while (!req_ready && w < 500) begin tick(); w++; end
    check("send_ready", N'(req_ready), N'(1));
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 400) begin tick(); cyc++; end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, N'(req_ready), N'(1));
    check({tag, "_rsp_valid"}, N'(rsp_valid), N'(0));
    check({tag, "_result"}, rsp_result, N'(0));
    check({tag, "_zero"}, N'(rsp_zero), N'(0));
    check({tag, "_err"}, N'(rsp_err), N'(0));
    check({tag, "_ctrl"}, N'(ALUCtrl), N'(OP_PASSB));
    check({tag, "_busa"}, BusA, N'(0));
    check({tag, "_busb"}, BusB, N'(0));
  endtask

  task automatic run_txn(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input int hold);
    logic [N-1:0] r; logic z, e; int lat, cyc;
    model(op, a, b, r, z, e, lat);
    rsp_ready = 1'b0;
    send(op, a, b);
    wait_rsp(cyc);
    check({tag, "_lat"}, N'(cyc), N'(lat));
    check({tag, "_valid"}, N'(rsp_valid), N'(1));
    check({tag, "_result"}, rsp_result, r);
    check({tag, "_zero"}, N'(rsp_zero), N'(z));
    check({tag, "_err"}, N'(rsp_err), N'(e));
    repeat (hold) begin
      tick();
      check({tag, "_hold_valid"}, N'(rsp_valid), N'(1));
      check({tag, "_hold_result"}, rsp_result, r);
    end
    check({tag, "_ctrl"}, N'(ALUCtrl), N'(m_ctrl));
    check({tag, "_busa"}, BusA, m_a);
    check({tag, "_busb"}, BusB, m_b);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done"}, N'(rsp_valid), N'(0));
  endtask

  task automatic reset_mid(input string tag, input logic [3:0] op, input int at_edge);
    send(op, N'(3), N'(5));
    repeat (at_edge - 1) tick();
    Reset = 1'b1;
    tick();
    check_reset_vals(tag);
    Reset = 1'b0;
    m_ctrl = OP_PASSB; m_a = '0; m_b = '0;
    rsp_ready = 1'b1;
    repeat (3) begin
      tick();
      check({tag, "_no_rsp"}, N'(rsp_valid), N'(0));
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r, a, b;
    logic z, e;
    int lat, cyc, hold;
    logic [3:0] ops [8];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_MUL, 4'b0011, 4'b1111};

    Reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    m_ctrl = OP_PASSB; m_a = '0; m_b = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    Reset = 1'b0;
    tick();

    // ADD 5+7 with consumer always ready: one-cycle response after E2.
    model(OP_ADD, N'(5), N'(7), r, z, e, lat);
    rsp_ready = 1'b1;
    send(OP_ADD, N'(5), N'(7));
    check("add_e0_valid", N'(rsp_valid), N'(0));
    tick();
    check("add_e1_valid", N'(rsp_valid), N'(0));
    tick();
    check("add_e2_valid", N'(rsp_valid), N'(1));
    check("add_result", rsp_result, r);
    check("add_zero", N'(rsp_zero), N'(0));
    check("add_err", N'(rsp_err), N'(0));
    tick();
    check("add_one_cycle", N'(rsp_valid), N'(0));
    check("add_ready_back", N'(req_ready), N'(1));
    rsp_ready = 1'b0;

    // SUB 9-9 with a stalled consumer and a competing request held meanwhile.
    model(OP_SUB, N'(9), N'(9), r, z, e, lat);
    send(OP_SUB, N'(9), N'(9));
    tick(); tick();
    req_valid = 1'b1; req_op = OP_ADD; req_a = N'(1); req_b = N'(2);
    for (int i = 0; i < 5; i++) begin
      check("sub_hold_valid", N'(rsp_valid), N'(1));
      check("sub_hold_result", rsp_result, N'(0));
      check("sub_hold_zero", N'(rsp_zero), N'(1));
      check("sub_hold_ready", N'(req_ready), N'(0));
      tick();
    end
    check("sub_busa_kept", BusA, N'(9));
    rsp_ready = 1'b1;
    tick();
    check("sub_handshake", N'(rsp_valid), N'(0));
    check("sub_ready_after", N'(req_ready), N'(1));
    model(OP_ADD, N'(1), N'(2), r, z, e, lat);
    tick();
    req_valid = 1'b0;
    check("b2b_accepted", N'(req_ready), N'(0));
    check("b2b_busa", BusA, N'(1));
    check("b2b_busb", BusB, N'(2));
    wait_rsp(cyc);
    check("b2b_lat", N'(cyc), N'(lat));
    check("b2b_result", rsp_result, r);
    tick();
    rsp_ready = 1'b0;

`ifdef ALU_SEQ_MUL_EN
    // MUL 3*5: ALU sees ADD 0+3 then 3+12, response after E8.
    model(OP_MUL, N'(3), N'(5), r, z, e, lat);
    send(OP_MUL, N'(3), N'(5));
    tick();
    check("mul_e1_ctrl", N'(ALUCtrl), N'(OP_ADD));
    check("mul_e1_busa", BusA, N'(0));
    check("mul_e1_busb", BusB, N'(3));
    repeat (4) tick();
    check("mul_e5_busa", BusA, N'(3));
    check("mul_e5_busb", BusB, N'(12));
    wait_rsp(cyc);
    check("mul_lat", N'(cyc + 5), N'(lat));
    check("mul_result", rsp_result, N'(15));
    check("mul_zero", N'(rsp_zero), N'(0));
    check("mul_err", N'(rsp_err), N'(0));
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    reset_mid("rst_mul", OP_MUL, 4);
`endif

    run_txn("illegal_0011", 4'b0011, N'(77), N'(88), 1);
    run_txn("op_1000", OP_MUL, N'(6), N'(7), 1);
    reset_mid("rst_issue", OP_ADD, 1);
    run_txn("add_after_rst", OP_ADD, N'(1), N'(1), 0);

    for (int i = 0; i < 30; i++) begin
      a = {$urandom(), $urandom()};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
      if ($urandom_range(0, 5) == 0) b = N'($urandom_range(0, 9));
      hold = $urandom_range(0, 3);
      run_txn("rand", ops[$urandom_range(0, 7)], a, b, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter n, default 64, datapath width of operands, result and ALU buses.
REQ-002 Parameter SETTLE, default 2, clock cycles the ALU is given to settle per operation (legal 1..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present; req_ready  output  1  block can accept.
REQ-006 req_op  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PassB, 1000 MUL (Configuration).
REQ-007 req_a, req_b  input  n  operands.
REQ-008 rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts.
REQ-009 rsp_result  output  n  result; rsp_zero  output  1  result==0; rsp_err  output  1  illegal op.
REQ-010 ALUCtrl  output  4, BusA  output  n, BusB  output  n  registered drive to the ALU.
REQ-011 BusW  input  n, Zero  input  1  ALU result and zero flag.

Function
REQ-012 States IDLE, ISSUE, MUL_EVAL, MUL_WAIT, RESP; req_ready = 1 only in IDLE.
REQ-013 Request accepted on an edge with req_valid & req_ready; operands and op captured that edge.
REQ-014 Basic op (AND/OR/ADD/SUB/PassB): accept edge E0 loads ALUCtrl=op, BusA=req_a, BusB=req_b, enters ISSUE.
REQ-015 ISSUE counts SETTLE edges; at edge E_SETTLE captures rsp_result=BusW, rsp_zero=Zero, rsp_err=0, enters RESP.
REQ-016 RESP holds rsp_valid=1 and all rsp_* stable until the edge with rsp_ready=1, then enters IDLE.
REQ-017 req_valid while not in IDLE is ignored (not accepted, not lost from the requester's view).
REQ-018 Illegal op: no ALU drive change; enters RESP at E0 with rsp_result=0, rsp_zero=1, rsp_err=1.
REQ-019 ALUCtrl/BusA/BusB hold their last driven values outside ISSUE/MUL_WAIT.
REQ-020 MUL: E0 loads mcand=req_a, mplier=req_b, acc=0, enters MUL_EVAL.
REQ-021 MUL_EVAL, one edge: if mplier==0 -> RESP with rsp_result=acc, rsp_zero=(acc==0) computed locally, rsp_err=0; else if mplier[0]=1 -> drive ALUCtrl=ADD, BusA=acc, BusB=mcand, enter MUL_WAIT; else mcand<<=1, mplier>>=1, stay.
REQ-022 MUL_WAIT counts SETTLE edges; on the last: acc=BusW, mcand<<=1, mplier>>=1, return to MUL_EVAL.
REQ-023 MUL product is the low n bits; overflow discarded, no flag.
REQ-024 Back-to-back: after response handshake edge, req_ready=1 for the next cycle; earliest next accept is that cycle's edge.

Reset
REQ-025 Reset overrides every state, including mid-ISSUE/MUL and RESP; in-flight operation discarded, no response.
REQ-026 Reset values: state IDLE, req_ready=1 after reset deasserts, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, ALUCtrl=0111, BusA=0, BusB=0, internal counters/acc/mcand/mplier=0.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN: defined -> op 1000 executes MUL per REQ-020..023, MUL_EVAL/MUL_WAIT present.
REQ-028 ALU_SEQ_MUL_EN undefined -> MUL states and registers absent; op 1000 is illegal per REQ-018.

Verification
REQ-029 Bench: 20 ns clock, SETTLE=2, n=64, behavioural ALU with 20 ns output delay and 1 ns Zero delay attached.
REQ-030 ADD a=5, b=7, rsp_ready=1 -> rsp_valid high after E2 for one cycle, result 12, zero 0, err 0.
REQ-031 SUB a=9, b=9 with rsp_ready held 0 for 5 cycles -> result 0, zero 1 held stable all 5 cycles; req_ready 0 throughout; second req_valid ignored.
REQ-032 MUL a=3, b=5 (MUL_EN defined) -> ALU sees ADD 0+3 then 3+12; rsp_valid high after E8, result 15, zero 0.
REQ-033 Op 1000 with MUL_EN undefined, and op 0011 in both builds -> rsp_valid after E0, result 0, zero 1, err 1, ALU inputs unchanged.
REQ-034 Reset asserted at E4 of MUL a=3, b=5 -> no response, all outputs at REQ-026 values, next ADD 1+1 returns 2 normally.
